// File: rtl/line_fetch_scheduler_if.sv
// SDRAM burst port 0 bundle shared by line fetches and download writes.
interface line_fetch_scheduler_if;
  logic [24:0] sd_addr;
  logic [15:0] sd_data;
  logic        sd_wr_req;
  logic        sd_rd_req;
  logic        sd_end_burst;
  logic        sd_data_available;
  logic [15:0] sd_q;

  modport master (
    output sd_addr, sd_data, sd_wr_req, sd_rd_req, sd_end_burst,
    input  sd_data_available, sd_q
  );

  modport slave (
    input  sd_addr, sd_data, sd_wr_req, sd_rd_req, sd_end_burst,
    output sd_data_available, sd_q
  );
endinterface

// File: rtl/line_fetch_scheduler.sv
// Per-line SDRAM burst fetch of the interleaved background/mask image into the
// pixel FIFOs, sharing the SDRAM port with image-download writes.
module line_fetch_scheduler #(
  parameter int WORDS_PER_LINE = 2160,
  parameter int LINES          = 720,
  parameter int REQ_GAP        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hblank,
  input  logic [9:0]                    video_y,
  input  logic                          dl_active,
  input  logic                          dl_wr,
  input  logic [24:0]                   dl_addr,
  input  logic [15:0]                   dl_data,
  line_fetch_scheduler_if.master        sd,
  output logic                          fifo_clear,
  output logic                          fifo_wr,
  output logic [23:0]                   bg_pixel,
  output logic [23:0]                   mask_pixel,
  output logic                          line_done,
  output logic                          late_line
);
  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam int GW = (REQ_GAP > 1) ? $clog2(REQ_GAP) : 1;
  localparam logic [CW-1:0] WPL    = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0] WPL_M2 = CW'(WORDS_PER_LINE - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(REQ_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BURST, S_GAP, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            hb_meta_q, hb_sync_q, hb_prev_q;
  logic            dav_q, dl_active_q;
  logic [24:0]     base_q, base_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]      byte_phase_q, byte_phase_d;
  logic [23:0]     bg_q, bg_d, mask_q, mask_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            restart_q, restart_d;
  logic            end_sent_q, end_sent_d;
  logic            fifo_wr_q, fifo_wr_d;
  logic            line_done_q, line_done_d;
  logic            late_line_q, late_line_d;
  logic            end_burst_q, end_burst_d;
  logic            wr_req_q, wr_req_d;
  logic [24:0]     wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;

  logic            start, dl_rise, dav_fall;
  logic [10:0]     y_inc;
  logic [9:0]      y_next;

  assign start    = hb_sync_q & ~hb_prev_q;
  assign dl_rise  = dl_active & ~dl_active_q;
  assign dav_fall = dav_q & ~sd.sd_data_available;
  assign y_inc    = {1'b0, video_y} + 11'd1;
  assign y_next   = (y_inc >= 11'(LINES)) ? 10'd0 : y_inc[9:0];

  // Download writes: granted when idle or whenever the download owns the port.
  always_comb begin
    wr_req_d  = dl_wr & ((state_q == S_IDLE) | dl_active);
    wr_addr_d = wr_req_d ? dl_addr : wr_addr_q;
    wr_data_d = wr_req_d ? dl_data : wr_data_q;
  end

  // Fetch FSM: start/abort take priority over normal burst progress.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    word_cnt_d   = word_cnt_q;
    byte_phase_d = byte_phase_q;
    bg_d         = bg_q;
    mask_d       = mask_q;
    gap_cnt_d    = gap_cnt_q;
    restart_d    = restart_q;
    end_sent_d   = end_sent_q;
    fifo_wr_d    = 1'b0;
    line_done_d  = 1'b0;
    late_line_d  = 1'b0;
    end_burst_d  = 1'b0;

    if (start) begin
      // New line: any word arriving this cycle is dropped.
      base_d       = 25'(y_next) * 25'(WORDS_PER_LINE);
      word_cnt_d   = '0;
      byte_phase_d = 2'd0;
      case (state_q)
        S_IDLE:  state_d = dl_active ? S_IDLE : S_REQ;
        S_DRAIN: restart_d = ~dl_active;
        default: begin
          late_line_d = 1'b1;
          end_burst_d = 1'b1;
          state_d     = S_DRAIN;
          restart_d   = ~dl_active;
        end
      endcase
    end else if (dl_rise && state_q != S_IDLE) begin
      end_burst_d = 1'b1;
      state_d     = S_DRAIN;
      restart_d   = 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          // Hold off the read request while a write occupies the port.
          if (!wr_req_q) begin
            state_d    = S_BURST;
            end_sent_d = 1'b0;
          end
        end
        S_BURST: begin
          if (sd.sd_data_available && word_cnt_q < WPL) begin
            bg_d         = {sd.sd_q[7:0],  bg_q[23:8]};
            mask_d       = {sd.sd_q[15:8], mask_q[23:8]};
            word_cnt_d   = word_cnt_q + CW'(1);
            byte_phase_d = (byte_phase_q == 2'd2) ? 2'd0 : byte_phase_q + 2'd1;
            fifo_wr_d    = (byte_phase_q == 2'd2);
            // Terminate the burst once, as the last two words come in.
            if (word_cnt_q >= WPL_M2 && !end_sent_q) begin
              end_burst_d = 1'b1;
              end_sent_d  = 1'b1;
            end
          end
          if (dav_fall) begin
            if (word_cnt_q == WPL) begin
              line_done_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_d = S_REQ;
          else                       gap_cnt_d = gap_cnt_q + GW'(1);
        end
        S_DRAIN: begin
          if (!sd.sd_data_available) begin
            state_d   = restart_q ? S_REQ : S_IDLE;
            restart_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State, datapath and pulse registers; hblank synchronizer and edge flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hb_meta_q    <= 1'b0;
      hb_sync_q    <= 1'b0;
      hb_prev_q    <= 1'b0;
      dav_q        <= 1'b0;
      dl_active_q  <= 1'b0;
      base_q       <= '0;
      word_cnt_q   <= '0;
      byte_phase_q <= '0;
      bg_q         <= '0;
      mask_q       <= '0;
      gap_cnt_q    <= '0;
      restart_q    <= 1'b0;
      end_sent_q   <= 1'b0;
      fifo_wr_q    <= 1'b0;
      line_done_q  <= 1'b0;
      late_line_q  <= 1'b0;
      end_burst_q  <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      hb_meta_q    <= hblank;
      hb_sync_q    <= hb_meta_q;
      hb_prev_q    <= hb_sync_q;
      dav_q        <= sd.sd_data_available;
      dl_active_q  <= dl_active;
      base_q       <= base_d;
      word_cnt_q   <= word_cnt_d;
      byte_phase_q <= byte_phase_d;
      bg_q         <= bg_d;
      mask_q       <= mask_d;
      gap_cnt_q    <= gap_cnt_d;
      restart_q    <= restart_d;
      end_sent_q   <= end_sent_d;
      fifo_wr_q    <= fifo_wr_d;
      line_done_q  <= line_done_d;
      late_line_q  <= late_line_d;
      end_burst_q  <= end_burst_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign fifo_clear      = start;
  assign fifo_wr         = fifo_wr_q;
  assign bg_pixel        = bg_q;
  assign mask_pixel      = mask_q;
  assign line_done       = line_done_q;
  assign late_line       = late_line_q;
  assign sd.sd_rd_req    = (state_q == S_REQ) & ~wr_req_q;
  assign sd.sd_wr_req    = wr_req_q;
  assign sd.sd_end_burst = end_burst_q;
  assign sd.sd_addr      = wr_req_q ? wr_addr_q : base_q + 25'(word_cnt_q);
  assign sd.sd_data      = wr_data_q;
endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Directed scenarios with random SDRAM data/latency, checked against a
// queue-based model of the line/pixel packing rules.
module tb_line_fetch_scheduler;
  localparam int W   = 2160;
  localparam int L   = 720;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset, hblank, dl_active, dl_wr;
  logic [9:0]  video_y;
  logic [24:0] dl_addr;
  logic [15:0] dl_data;
  logic        fifo_clear, fifo_wr, line_done, late_line;
  logic [23:0] bg_pixel, mask_pixel;

  line_fetch_scheduler_if sd_if();

  line_fetch_scheduler #(.WORDS_PER_LINE(W), .LINES(L), .REQ_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .hblank(hblank), .video_y(video_y),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .sd(sd_if), .fifo_clear(fifo_clear), .fifo_wr(fifo_wr),
    .bg_pixel(bg_pixel), .mask_pixel(mask_pixel),
    .line_done(line_done), .late_line(late_line)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  // monitor-owned event counters
  int n_fwr = 0, n_ld = 0, n_late = 0, n_eb = 0, n_both = 0;
  logic [23:0] obs_bg[$], obs_mk[$];
  // model state (initial block only)
  logic [23:0] exp_bg[$], exp_mk[$];
  logic [15:0] grp[$], preset[$];
  int m_cnt, eb_at, fwr0, ld0, eb0, ob0;

  always @(negedge clk) begin
    if (fifo_wr) begin
      n_fwr++;
      obs_bg.push_back(bg_pixel);
      obs_mk.push_back(mask_pixel);
    end
    if (line_done) n_ld++;
    if (late_line) n_late++;
    if (sd_if.sd_end_burst) n_eb++;
    if (sd_if.sd_rd_req && sd_if.sd_wr_req) n_both++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lat();
    int k = 1 + int'($urandom_range(0, 3));
    repeat (k) tick();
  endtask

  function automatic int exp_base(input int vy);
    int y = vy + 1;
    if (y >= L) y = 0;
    return y * W;
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_pulses"}, {fifo_clear, fifo_wr, line_done, late_line, sd_if.sd_rd_req,
                           sd_if.sd_wr_req, sd_if.sd_end_burst}, 0);
    chk({tag, "_bg"}, bg_pixel, 0);
    chk({tag, "_mask"}, mask_pixel, 0);
    chk({tag, "_addr"}, sd_if.sd_addr, 0);
    chk({tag, "_data"}, sd_if.sd_data, 0);
  endtask

  task automatic new_line();
    m_cnt = 0; eb_at = -1;
    grp.delete(); exp_bg.delete(); exp_mk.delete();
    fwr0 = n_fwr; ld0 = n_ld; eb0 = n_eb; ob0 = obs_bg.size();
  endtask

  // Raise hblank and wait for the fifo_clear of the synchronized start.
  task automatic do_start(input int vy);
    bit ok = 0;
    video_y = 10'(vy);
    hblank = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (fifo_clear) ok = 1;
    end
    hblank = 1'b0;
    chk("start_fifo_clear", ok, 1);
  endtask

  task automatic wait_rd(output int n, output logic [24:0] a);
    n = 0; a = 'x;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (sd_if.sd_rd_req) begin n = i; a = sd_if.sd_addr; end
    end
    if (n == 0) chk("rd_req_timeout", 0, 1);
  endtask

  task automatic deliver(input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      if (preset.size() > 0) w = preset.pop_front();
      else w = 16'($urandom);
      sd_if.sd_q = w;
      sd_if.sd_data_available = 1'b1;
      tick();
      if (m_cnt < W) begin
        grp.push_back(w);
        m_cnt++;
        if (grp.size() == 3) begin
          exp_bg.push_back({grp[2][7:0], grp[1][7:0], grp[0][7:0]});
          exp_mk.push_back({grp[2][15:8], grp[1][15:8], grp[0][15:8]});
          grp.delete();
        end
        if (sd_if.sd_end_burst && eb_at < 0) eb_at = m_cnt - 1;
      end
    end
    if (drop) sd_if.sd_data_available = 1'b0;
  endtask

  task automatic end_line_check(input string tag);
    tick();
    chk({tag, "_fifo_wr_cnt"}, n_fwr - fwr0, W / 3);
    chk({tag, "_line_done_cnt"}, n_ld - ld0, 1);
    chk({tag, "_end_burst_cnt"}, n_eb - eb0, 1);
    for (int i = 0; i < exp_bg.size(); i++) begin
      logic [23:0] ob, om;
      ob = (ob0 + i < obs_bg.size()) ? obs_bg[ob0 + i] : 24'hxxxxxx;
      om = (ob0 + i < obs_mk.size()) ? obs_mk[ob0 + i] : 24'hxxxxxx;
      chk({tag, "_bg"}, ob, exp_bg[i]);
      chk({tag, "_mask"}, om, exp_mk[i]);
    end
  endtask

  initial begin
    int n, late0;
    logic [24:0] a;
    reset = 1'b1; hblank = 1'b0; video_y = '0; dl_active = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; sd_if.sd_data_available = 1'b0; sd_if.sd_q = '0;
    repeat (3) tick();
    chk_rst("reset0");
    reset = 1'b0;
    repeat (2) tick();

    // Line y=5 in one burst with two surplus words; fixed first pixel triple.
    preset.push_back(16'h1122); preset.push_back(16'h3344); preset.push_back(16'h5566);
    do_start(4);
    new_line();
    wait_rd(n, a);
    chk("l5_rd_latency", n, 1);
    chk("l5_rd_addr", a, exp_base(4));
    lat();
    deliver(3, 0);
    chk("pix_fifo_wr", fifo_wr, 1);
    chk("pix_bg", bg_pixel, 24'h664422);
    chk("pix_mask", mask_pixel, 24'h553311);
    deliver(W - 1, 1);
    tick();
    chk("l5_line_done", line_done, 1);
    chk("l5_end_burst_word", eb_at, W - 2);
    end_line_check("l5");

    // Last line wraps to y=0; burst breaks after 512 words.
    do_start(719);
    new_line();
    wait_rd(n, a);
    chk("l0_rd_addr", a, 0);
    lat();
    deliver(512, 1);
    wait_rd(n, a);
    chk("gap_rereq_cycles", n, GAP + 1);
    chk("gap_rereq_addr", a, 512);
    lat();
    deliver(W - 512, 1);
    tick();
    chk("l0_line_done", line_done, 1);
    end_line_check("l0");

    // Late line: hblank rises again mid-fetch with data still streaming.
    do_start(9);
    new_line();
    wait_rd(n, a);
    chk("l10_rd_addr", a, exp_base(9));
    lat();
    deliver(1000, 0);
    late0 = n_late;
    do_start(19);
    tick();
    chk("late_pulse", late_line, 1);
    chk("late_end_burst", sd_if.sd_end_burst, 1);
    sd_if.sd_data_available = 1'b0;
    wait_rd(n, a);
    new_line();
    chk("late_restart_addr", a, exp_base(19));
    lat();
    deliver(W, 1);
    tick();
    chk("l20_line_done", line_done, 1);
    end_line_check("l20");
    chk("late_cnt", n_late - late0, 1);

    // Download takes over mid-fetch.
    do_start(29);
    new_line();
    wait_rd(n, a);
    lat();
    deliver(300, 0);
    dl_wr = 1'b1; dl_addr = 25'h1ABCDE; dl_data = 16'hBEEF;
    tick();
    chk("wr_blocked_in_fetch", sd_if.sd_wr_req, 0);
    dl_wr = 1'b0;
    dl_active = 1'b1;
    tick();
    chk("dl_abort_end_burst", sd_if.sd_end_burst, 1);
    sd_if.sd_data_available = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [24:0] wa;
      logic [15:0] wd;
      wa = 25'($urandom);
      wd = 16'($urandom);
      dl_addr = wa; dl_data = wd; dl_wr = 1'b1;
      tick();
      chk("dl_wr_req", sd_if.sd_wr_req, 1);
      chk("dl_wr_addr", sd_if.sd_addr, wa);
      chk("dl_wr_data", sd_if.sd_data, wd);
      dl_wr = 1'b0;
      tick();
      chk("dl_wr_req_drop", sd_if.sd_wr_req, 0);
    end
    chk("dl_no_line_done", n_ld - ld0, 0);
    do_start(99);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sd_if.sd_rd_req) n++;
    end
    chk("dl_start_stays_idle", n, 0);
    dl_active = 1'b0;
    tick();
    dl_addr = 25'h0123456; dl_data = 16'h5A5A; dl_wr = 1'b1;
    tick();
    chk("idle_wr_req", sd_if.sd_wr_req, 1);
    chk("idle_wr_addr", sd_if.sd_addr, 25'h0123456);
    dl_wr = 1'b0;
    tick();

    // Reset mid-burst, then a clean fetch.
    do_start(39);
    new_line();
    wait_rd(n, a);
    lat();
    deliver(100, 0);
    #2 reset = 1'b1;
    #1 chk_rst("reset_mid");
    sd_if.sd_data_available = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    do_start(49);
    new_line();
    wait_rd(n, a);
    chk("post_rst_rd_latency", n, 1);
    chk("post_rst_rd_addr", a, exp_base(49));
    lat();
    deliver(W, 1);
    tick();
    chk("l50_line_done", line_done, 1);
    end_line_check("l50");

    chk("rd_wr_overlap", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
